// File: rtl/vpu_pkg.sv
// rtl/vpu_pkg.sv - shared opcodes, IR field positions, issue FSM states
package vpu_pkg;

    localparam logic [4:0] OP_MOV = 5'd1;
    localparam logic [4:0] OP_ADD = 5'd2;
    localparam logic [4:0] OP_SUB = 5'd3;
    localparam logic [4:0] OP_MUL = 5'd4;
    localparam logic [4:0] OP_OR  = 5'd5;
    localparam logic [4:0] OP_AND = 5'd6;
    localparam logic [4:0] OP_XOR = 5'd7;

    localparam int OPER_MSB  = 31;
    localparam int OPER_LSB  = 27;
    localparam int RDST_MSB  = 26;
    localparam int RDST_LSB  = 22;
    localparam int RSRC1_MSB = 21;
    localparam int RSRC1_LSB = 17;
    localparam int IMM_BIT   = 16;
    localparam int RSRC2_MSB = 15;
    localparam int RSRC2_LSB = 11;
    localparam int ISRC_MSB  = 15;
    localparam int ISRC_LSB  = 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESENT,
        ST_GAP
    } issue_state_t;

    function automatic logic is_legal_op(input logic [4:0] op);
        return (op >= OP_MOV) && (op <= OP_XOR);
    endfunction

endpackage

// File: rtl/vpu_issue_fifo.sv
// rtl/vpu_issue_fifo.sv - synchronous FIFO exposing head and the entry behind it
module vpu_issue_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [WIDTH-1:0]         head_next,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] LEVEL_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0] LEVEL_ONE  = (AW + 1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full      = (level == LEVEL_FULL);
    assign empty     = (level == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head      = mem[rd_ptr];
    assign head_next = mem[rd_ptr + AW'(1)];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                level <= level + LEVEL_ONE;
            end else if (!do_push && do_pop) begin
                level <= level - LEVEL_ONE;
            end
        end
    end

endmodule

// File: rtl/vpu_issue.sv
// rtl/vpu_issue.sv - encodes operation requests into IR words and issues them with a gap
module vpu_issue
    import vpu_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int ISSUE_GAP = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [4:0]             req_op,
    input  logic                   req_imm_mode,
    input  logic [4:0]             req_rdst,
    input  logic [4:0]             req_rsrc1,
    input  logic [4:0]             req_rsrc2,
    input  logic [15:0]            req_imm,
    output logic [31:0]            ir_out,
    output logic                   ir_valid,
    input  logic                   ir_ready,
    output logic                   err_illegal,
    output logic [15:0]            issued_cnt,
    output logic [$clog2(DEPTH):0] fifo_level
);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam int GW = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((ISSUE_GAP > 0) ? ISSUE_GAP - 1 : 0);

    issue_state_t  state;
    issue_state_t  state_n;
    logic [31:0]   enc;
    logic          req_fire;
    logic          legal;
    logic          push;
    logic          pop;
    logic          load;
    logic [31:0]   load_data;
    logic [31:0]   head;
    logic [31:0]   head_next;
    logic          full;
    logic          empty;
    logic [GW-1:0] gap_cnt;

    always_comb begin
        enc = '0;
        enc[OPER_MSB:OPER_LSB]   = req_op;
        enc[RDST_MSB:RDST_LSB]   = req_rdst;
        enc[RSRC1_MSB:RSRC1_LSB] = req_rsrc1;
        enc[IMM_BIT]             = req_imm_mode;
        if (req_imm_mode) begin
            enc[ISRC_MSB:ISRC_LSB] = req_imm;
        end else begin
            enc[RSRC2_MSB:RSRC2_LSB] = req_rsrc2;
        end
    end

    assign req_ready = !full;
    assign req_fire  = req_valid && req_ready;
    assign legal     = is_legal_op(req_op);
    assign push      = req_fire && legal;
    assign ir_valid  = (state == ST_PRESENT);
    assign pop       = ir_valid && ir_ready;

    vpu_issue_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (enc),
        .pop       (pop),
        .head      (head),
        .head_next (head_next),
        .full      (full),
        .empty     (empty),
        .level     (fifo_level)
    );

    // The presented entry stays in the FIFO until its handshake, so a zero-gap
    // reissue must take the entry behind the one being popped.
    always_comb begin
        state_n   = state;
        load      = 1'b0;
        load_data = head;
        case (state)
            ST_IDLE: begin
                if (!empty) begin
                    state_n = ST_PRESENT;
                    load    = 1'b1;
                end
            end
            ST_PRESENT: begin
                if (ir_ready) begin
                    if (ISSUE_GAP > 0) begin
                        state_n = ST_GAP;
                    end else if (fifo_level >= LW'(2)) begin
                        state_n   = ST_PRESENT;
                        load      = 1'b1;
                        load_data = head_next;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    if (!empty) begin
                        state_n = ST_PRESENT;
                        load    = 1'b1;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            ir_out      <= '0;
            err_illegal <= 1'b0;
            issued_cnt  <= '0;
            gap_cnt     <= '0;
        end else begin
            state       <= state_n;
            err_illegal <= req_fire && !legal;
            gap_cnt     <= (state == ST_GAP) ? gap_cnt + GW'(1) : '0;
            if (load) begin
                ir_out <= load_data;
            end
            if (pop) begin
                issued_cnt <= issued_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_vpu_issue.sv
// tb/tb_vpu_issue.sv - directed self-checking bench for vpu_issue
module tb_vpu_issue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_valid_g = 1'b0;
    logic [4:0]  req_op = '0;
    logic        req_imm_mode = 1'b0;
    logic [4:0]  req_rdst = '0;
    logic [4:0]  req_rsrc1 = '0;
    logic [4:0]  req_rsrc2 = '0;
    logic [15:0] req_imm = '0;
    logic        ir_ready = 1'b0;
    logic        ir_ready_g = 1'b0;

    logic        req_ready, req_ready_g;
    logic [31:0] ir_out, ir_out_g;
    logic        ir_valid, ir_valid_g;
    logic        err_illegal, err_illegal_g;
    logic [15:0] issued_cnt, issued_cnt_g;
    logic [2:0]  fifo_level, fifo_level_g;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vpu_issue #(.DEPTH(4), .ISSUE_GAP(0)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_imm_mode(req_imm_mode), .req_rdst(req_rdst),
        .req_rsrc1(req_rsrc1), .req_rsrc2(req_rsrc2), .req_imm(req_imm),
        .ir_out(ir_out), .ir_valid(ir_valid), .ir_ready(ir_ready),
        .err_illegal(err_illegal), .issued_cnt(issued_cnt), .fifo_level(fifo_level)
    );

    vpu_issue #(.DEPTH(4), .ISSUE_GAP(2)) dut_g (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_g), .req_ready(req_ready_g),
        .req_op(req_op), .req_imm_mode(req_imm_mode), .req_rdst(req_rdst),
        .req_rsrc1(req_rsrc1), .req_rsrc2(req_rsrc2), .req_imm(req_imm),
        .ir_out(ir_out_g), .ir_valid(ir_valid_g), .ir_ready(ir_ready_g),
        .err_illegal(err_illegal_g), .issued_cnt(issued_cnt_g), .fifo_level(fifo_level_g)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [4:0] op, input logic mode, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [15:0] imm);
        req_op = op; req_imm_mode = mode; req_rdst = rd;
        req_rsrc1 = rs1; req_rsrc2 = rs2; req_imm = imm;
    endtask

    function automatic logic [31:0] xori_word(input int i);
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [15:0] imm;
        rd  = 5'(i);
        rs1 = 5'(i + 1);
        imm = 16'h0100 + 16'(i);
        return {5'd7, rd, rs1, 1'b1, imm};
    endfunction

    task automatic do_reset;
        rst_n = 1'b0;
        tick;
        tick;
        rst_n = 1'b1;
    endtask

    int err_seen;
    logic [3:0] pat;

    initial begin
        do_reset;
        check("rst_level", 32'(fifo_level), 0);
        check("rst_req_ready", 32'(req_ready), 1);
        check("rst_ir_valid", 32'(ir_valid), 0);
        check("rst_ir_out", ir_out, 0);
        check("rst_err", 32'(err_illegal), 0);
        check("rst_cnt", 32'(issued_cnt), 0);

        // ADDI latency and encoding
        set_req(5'd2, 1'b1, 5'd0, 5'd2, 5'd0, 16'd4);
        req_valid = 1'b1;
        tick;
        req_valid = 1'b0;
        check("addi_n1_valid", 32'(ir_valid), 0);
        tick;
        check("addi_n2_valid", 32'(ir_valid), 1);
        check("addi_ir", ir_out, 32'h10050004);
        ir_ready = 1'b1;
        tick;
        ir_ready = 1'b0;
        check("addi_cnt", 32'(issued_cnt), 1);
        check("addi_idle", 32'(ir_valid), 0);

        // Register MOV
        set_req(5'd1, 1'b0, 5'd4, 5'd7, 5'd5, 16'hFFFF);
        req_valid = 1'b1;
        tick;
        req_valid = 1'b0;
        tick;
        check("mov_valid", 32'(ir_valid), 1);
        check("mov_ir", ir_out, 32'h090E2800);
        ir_ready = 1'b1;
        tick;
        ir_ready = 1'b0;

        // Fill FIFO while stalled, then drain
        do_reset;
        for (int i = 0; i < 5; i++) begin
            set_req(5'd7, 1'b1, 5'(i), 5'(i + 1), 5'd0, 16'h0100 + 16'(i));
            req_valid = 1'b1;
            check($sformatf("fill_ready_%0d", i), 32'(req_ready), (i < 4) ? 1 : 0);
            tick;
        end
        req_valid = 1'b0;
        check("full_level", 32'(fifo_level), 4);
        check("full_ready", 32'(req_ready), 0);
        tick;
        tick;
        check("stall_valid", 32'(ir_valid), 1);
        check("stall_ir", ir_out, xori_word(0));
        ir_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            check($sformatf("drain_valid_%0d", j), 32'(ir_valid), 1);
            check($sformatf("drain_ir_%0d", j), ir_out, xori_word(j));
            tick;
            if (j == 0) check("ready_after_pop", 32'(req_ready), 1);
        end
        ir_ready = 1'b0;
        check("drain_done", 32'(ir_valid), 0);
        check("drain_cnt", 32'(issued_cnt), 4);

        // Illegal opcode between two ANDI
        do_reset;
        ir_ready = 1'b1;
        err_seen = 0;
        set_req(5'd6, 1'b1, 5'd1, 5'd2, 5'd0, 16'h00F0);
        req_valid = 1'b1;
        tick;
        err_seen += int'(err_illegal);
        set_req(5'd9, 1'b1, 5'd3, 5'd4, 5'd0, 16'h1234);
        tick;
        err_seen += int'(err_illegal);
        check("err_pulse", 32'(err_illegal), 1);
        set_req(5'd6, 1'b1, 5'd5, 5'd6, 5'd0, 16'h000F);
        tick;
        err_seen += int'(err_illegal);
        req_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick;
            err_seen += int'(err_illegal);
        end
        ir_ready = 1'b0;
        check("err_count", 32'(err_seen), 1);
        check("illegal_cnt", 32'(issued_cnt), 2);

        // ISSUE_GAP=2 spacing and ISSUE_GAP=0 back-to-back
        do_reset;
        for (int i = 0; i < 3; i++) begin
            set_req(5'd7, 1'b1, 5'(i), 5'(i + 1), 5'd0, 16'h0100 + 16'(i));
            req_valid = 1'b1;
            req_valid_g = 1'b1;
            tick;
        end
        req_valid = 1'b0;
        req_valid_g = 1'b0;
        tick;
        ir_ready_g = 1'b1;
        ir_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            check($sformatf("gap_valid_%0d", k), 32'(ir_valid_g), (k % 3 == 0) ? 1 : 0);
            if (k % 3 == 0) check($sformatf("gap_ir_%0d", k), ir_out_g, xori_word(k / 3));
            if (k < 4) pat[k] = ir_valid;
            tick;
        end
        ir_ready_g = 1'b0;
        ir_ready = 1'b0;
        check("gap_cnt", 32'(issued_cnt_g), 3);
        check("b2b_pattern", 32'(pat), 32'h7);
        check("b2b_cnt", 32'(issued_cnt), 3);

        // Reset mid-operation
        for (int i = 0; i < 4; i++) begin
            set_req(5'd7, 1'b1, 5'(i), 5'(i + 1), 5'd0, 16'h0100 + 16'(i));
            req_valid = 1'b1;
            tick;
        end
        req_valid = 1'b0;
        tick;
        check("pre_rst_valid", 32'(ir_valid), 1);
        rst_n = 1'b0;
        tick;
        check("mid_rst_valid", 32'(ir_valid), 0);
        check("mid_rst_level", 32'(fifo_level), 0);
        check("mid_rst_cnt", 32'(issued_cnt), 0);
        check("mid_rst_ir", ir_out, 0);
        check("mid_rst_err", 32'(err_illegal), 0);
        rst_n = 1'b1;
        set_req(5'd1, 1'b0, 5'd4, 5'd7, 5'd5, 16'h0000);
        req_valid = 1'b1;
        tick;
        req_valid = 1'b0;
        tick;
        check("post_rst_valid", 32'(ir_valid), 1);
        check("post_rst_ir", ir_out, 32'h090E2800);
        ir_ready = 1'b1;
        tick;
        ir_ready = 1'b0;
        check("post_rst_cnt", 32'(issued_cnt), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
